// File: rtl/dla_ctrl_pkg.sv
// dla_ctrl_pkg
//   Shared definitions for the DLA control block: the register map, the
//   sheet-generator state encoding and the stride/pool log2 code helper.
//   Imported by dla_ctrl (register file + read mux) and dla_sheet_gen (FSM).

package dla_ctrl_pkg;

  // Configuration registers (RW, reset 0)
  localparam logic [31:0] ADDR_KERNEL_SIZE      = 32'h01;
  localparam logic [31:0] ADDR_STRIDE           = 32'h02;
  localparam logic [31:0] ADDR_PAD_SIZE         = 32'h03;
  localparam logic [31:0] ADDR_POOL_SIZE        = 32'h04;
  localparam logic [31:0] ADDR_VALID_NUM        = 32'h05;
  localparam logic [31:0] ADDR_IF_LAYER_NUM     = 32'h06;
  localparam logic [31:0] ADDR_IFMAP_LENGTH     = 32'h07;
  localparam logic [31:0] ADDR_IFMAP_SIZE       = 32'h08;
  localparam logic [31:0] ADDR_OFMAP_SIZE       = 32'h09;
  localparam logic [31:0] ADDR_QTF_MODE         = 32'h0a;
  localparam logic [31:0] ADDR_POOL_MODE        = 32'h0b;
  localparam logic [31:0] ADDR_BIAS             = 32'h0c;
  localparam logic [31:0] ADDR_BIAS_CHN         = 32'h0d;
  localparam logic [31:0] ADDR_OF_LAYER_NUM     = 32'h0e;
  localparam logic [31:0] ADDR_IF_TILE_LENGTH_0 = 32'h0f;
  localparam logic [31:0] ADDR_IF_TILE_LENGTH_1 = 32'h10;
  localparam logic [31:0] ADDR_IF_TILE_LENGTH_2 = 32'h11;
  localparam logic [31:0] ADDR_IF_TILE_LENGTH_3 = 32'h12;
  localparam logic [31:0] ADDR_IF_TILE_HEIGHT_0 = 32'h13;
  localparam logic [31:0] ADDR_IF_TILE_HEIGHT_1 = 32'h14;
  localparam logic [31:0] ADDR_IF_TILE_HEIGHT_2 = 32'h15;
  localparam logic [31:0] ADDR_IF_TILE_HEIGHT_3 = 32'h16;
  localparam logic [31:0] ADDR_IF_TILE_NUMBER_0 = 32'h17;
  localparam logic [31:0] ADDR_IF_TILE_NUMBER_1 = 32'h18;
  localparam logic [31:0] ADDR_IF_TILE_NUMBER_2 = 32'h19;
  localparam logic [31:0] ADDR_IF_TILE_NUMBER_3 = 32'h1a;

  // Control registers
  localparam logic [31:0] ADDR_REG_INIT         = 32'h1b;
  localparam logic [31:0] ADDR_SHEET_GEN_START  = 32'h1c;

  // Status registers (read-only)
  localparam logic [31:0] ADDR_SHEET_GEN_FINISH = 32'h1d;
  localparam logic [31:0] ADDR_OF_TILE_LENGTH_0 = 32'h1e;
  localparam logic [31:0] ADDR_OF_TILE_LENGTH_1 = 32'h1f;
  localparam logic [31:0] ADDR_OF_TILE_LENGTH_2 = 32'h20;
  localparam logic [31:0] ADDR_OF_TILE_LENGTH_3 = 32'h21;
  localparam logic [31:0] ADDR_OF_TILE_HEIGHT_0 = 32'h22;
  localparam logic [31:0] ADDR_OF_TILE_HEIGHT_1 = 32'h23;
  localparam logic [31:0] ADDR_OF_TILE_HEIGHT_2 = 32'h24;
  localparam logic [31:0] ADDR_OF_TILE_HEIGHT_3 = 32'h25;
  localparam logic [31:0] ADDR_TILE_COUNT       = 32'h26;

  // Four tile classes, one 32-bit word each
  typedef logic [3:0][31:0] word4_t;

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_CALC = 2'd1,
    GEN_WALK = 2'd2,
    GEN_DONE = 2'd3
  } gen_state_t;

  // Shift amount for a stride/pool size; unsupported sizes behave like 1
  function automatic logic [1:0] log2_code(input logic [31:0] value);
    logic [1:0] code;
    case (value)
      32'd2:   code = 2'd1;
      32'd4:   code = 2'd2;
      default: code = 2'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/dla_sheet_gen.sv
// dla_sheet_gen
//   Sheet generator: for each of the four tile classes it derives the output
//   tile length/height in one CALC cycle, then spends one WALK cycle per tile
//   counting tiles, and finally raises finish in a single DONE cycle.
// Ports
//   clock, rst_n          clock and synchronous active-low reset
//   abort                 REG_INIT: clears status and returns to IDLE
//   start                 decoded START write (data[0]=1)
//   init_begin            hardware arm; start is only accepted while high
//   kernel_size, stride, pool_size, if_tile_*   configuration inputs
//   busy, finish          generator status
//   of_tile_length/height per-class output dimensions
//   tile_count            tiles walked since the last accepted start

module dla_sheet_gen
  import dla_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        start,
  input  logic        init_begin,
  input  logic [31:0] kernel_size,
  input  logic [31:0] stride,
  input  logic [31:0] pool_size,
  input  word4_t      if_tile_length,
  input  word4_t      if_tile_height,
  input  word4_t      if_tile_number,
  output logic        busy,
  output logic        finish,
  output word4_t      of_tile_length,
  output word4_t      of_tile_height,
  output logic [31:0] tile_count
);

  gen_state_t  state;
  logic [1:0]  k;
  logic [31:0] walk_cnt;
  logic [1:0]  s_code;
  logic [1:0]  p_code;
  logic        last_class;

  // Output dimension of one axis; a tile smaller than the kernel yields 0
  function automatic logic [31:0] out_dim(input logic [31:0] dim,
                                          input logic [31:0] kernel,
                                          input logic [1:0]  s,
                                          input logic [1:0]  p);
    logic [31:0] span;
    if (dim < kernel) begin
      return '0;
    end
    span = (dim - kernel) >> s;
    return (span + 32'd1) >> p;
  endfunction

  assign s_code     = log2_code(stride);
  assign p_code     = log2_code(pool_size);
  assign last_class = (k == 2'd3);

  // Generator FSM. Classes with zero tiles skip WALK and go straight to the
  // next CALC, so the run always costs 4 CALC + sum(tiles) WALK + 1 DONE.
  // busy is kept as its own register so it is high exactly outside IDLE.
  always_ff @(posedge clock) begin
    if (!rst_n || abort) begin
      state          <= GEN_IDLE;
      k              <= 2'd0;
      walk_cnt       <= '0;
      busy           <= 1'b0;
      finish         <= 1'b0;
      of_tile_length <= '0;
      of_tile_height <= '0;
      tile_count     <= '0;
    end else begin
      case (state)
        GEN_IDLE: begin
          if (start && init_begin) begin
            state      <= GEN_CALC;
            busy       <= 1'b1;
            finish     <= 1'b0;
            tile_count <= '0;
            k          <= 2'd0;
          end
        end
        GEN_CALC: begin
          of_tile_length[k] <= out_dim(if_tile_length[k], kernel_size, s_code, p_code);
          of_tile_height[k] <= out_dim(if_tile_height[k], kernel_size, s_code, p_code);
          walk_cnt          <= '0;
          if (if_tile_number[k] != 32'd0) begin
            state <= GEN_WALK;
          end else if (last_class) begin
            state <= GEN_DONE;
          end else begin
            k <= k + 2'd1;
          end
        end
        GEN_WALK: begin
          tile_count <= tile_count + 32'd1;
          walk_cnt   <= walk_cnt + 32'd1;
          if (walk_cnt == if_tile_number[k] - 32'd1) begin
            if (last_class) begin
              state <= GEN_DONE;
            end else begin
              k     <= k + 2'd1;
              state <= GEN_CALC;
            end
          end
        end
        GEN_DONE: begin
          finish <= 1'b1;
          busy   <= 1'b0;
          state  <= GEN_IDLE;
        end
        default: begin
          state <= GEN_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dla_ctrl.sv
// dla_ctrl
//   Register-mapped control block for the DLA datapath. Holds the layer and
//   tiling configuration, decodes REG_INIT / SHEET_GEN_START and exposes the
//   sheet generator status through a registered read port.
// Ports
//   clock, rst_n                          clock and synchronous active-low reset
//   reg_addr_wr, reg_data_wr, reg_en_wr   register write port
//   reg_addr_rd, reg_en_rd                register read request
//   reg_data_rd                           registered read data
//   init_begin                            hardware arm for sheet generation

module dla_ctrl
  import dla_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic [31:0] reg_addr_wr,
  input  logic [31:0] reg_data_wr,
  input  logic        reg_en_wr,
  input  logic [31:0] reg_addr_rd,
  input  logic        reg_en_rd,
  output logic [31:0] reg_data_rd,
  input  logic        init_begin
);

  logic [31:0] kernel_size;
  logic [31:0] stride;
  logic [31:0] pad_size;
  logic [31:0] pool_size;
  logic [31:0] valid_num;
  logic [31:0] if_layer_num;
  logic [31:0] ifmap_length;
  logic [31:0] ifmap_size;
  logic [31:0] ofmap_size;
  logic [31:0] qtf_mode;
  logic [31:0] pool_mode;
  logic [31:0] bias;
  logic [31:0] bias_chn;
  logic [31:0] of_layer_num;
  word4_t      if_tile_length;
  word4_t      if_tile_height;
  word4_t      if_tile_number;

  logic        reg_init;
  logic        gen_start;
  logic        busy;
  logic        finish;
  word4_t      of_tile_length;
  word4_t      of_tile_height;
  logic [31:0] tile_count;

  logic        rd_en_q;
  logic [31:0] rd_addr_q;
  logic [31:0] rd_word;

  assign reg_init  = reg_en_wr && (reg_addr_wr == ADDR_REG_INIT) && reg_data_wr[0];
  assign gen_start = reg_en_wr && (reg_addr_wr == ADDR_SHEET_GEN_START) && reg_data_wr[0];

  // Configuration register file. REG_INIT wipes it like reset does, and the
  // generator owns the configuration while busy, so writes are dropped then.
  always_ff @(posedge clock) begin
    if (!rst_n || reg_init) begin
      kernel_size    <= '0;
      stride         <= '0;
      pad_size       <= '0;
      pool_size      <= '0;
      valid_num      <= '0;
      if_layer_num   <= '0;
      ifmap_length   <= '0;
      ifmap_size     <= '0;
      ofmap_size     <= '0;
      qtf_mode       <= '0;
      pool_mode      <= '0;
      bias           <= '0;
      bias_chn       <= '0;
      of_layer_num   <= '0;
      if_tile_length <= '0;
      if_tile_height <= '0;
      if_tile_number <= '0;
    end else if (reg_en_wr && !busy) begin
      case (reg_addr_wr)
        ADDR_KERNEL_SIZE:      kernel_size       <= reg_data_wr;
        ADDR_STRIDE:           stride            <= reg_data_wr;
        ADDR_PAD_SIZE:         pad_size          <= reg_data_wr;
        ADDR_POOL_SIZE:        pool_size         <= reg_data_wr;
        ADDR_VALID_NUM:        valid_num         <= reg_data_wr;
        ADDR_IF_LAYER_NUM:     if_layer_num      <= reg_data_wr;
        ADDR_IFMAP_LENGTH:     ifmap_length      <= reg_data_wr;
        ADDR_IFMAP_SIZE:       ifmap_size        <= reg_data_wr;
        ADDR_OFMAP_SIZE:       ofmap_size        <= reg_data_wr;
        ADDR_QTF_MODE:         qtf_mode          <= reg_data_wr;
        ADDR_POOL_MODE:        pool_mode         <= reg_data_wr;
        ADDR_BIAS:             bias              <= reg_data_wr;
        ADDR_BIAS_CHN:         bias_chn          <= reg_data_wr;
        ADDR_OF_LAYER_NUM:     of_layer_num      <= reg_data_wr;
        ADDR_IF_TILE_LENGTH_0: if_tile_length[0] <= reg_data_wr;
        ADDR_IF_TILE_LENGTH_1: if_tile_length[1] <= reg_data_wr;
        ADDR_IF_TILE_LENGTH_2: if_tile_length[2] <= reg_data_wr;
        ADDR_IF_TILE_LENGTH_3: if_tile_length[3] <= reg_data_wr;
        ADDR_IF_TILE_HEIGHT_0: if_tile_height[0] <= reg_data_wr;
        ADDR_IF_TILE_HEIGHT_1: if_tile_height[1] <= reg_data_wr;
        ADDR_IF_TILE_HEIGHT_2: if_tile_height[2] <= reg_data_wr;
        ADDR_IF_TILE_HEIGHT_3: if_tile_height[3] <= reg_data_wr;
        ADDR_IF_TILE_NUMBER_0: if_tile_number[0] <= reg_data_wr;
        ADDR_IF_TILE_NUMBER_1: if_tile_number[1] <= reg_data_wr;
        ADDR_IF_TILE_NUMBER_2: if_tile_number[2] <= reg_data_wr;
        ADDR_IF_TILE_NUMBER_3: if_tile_number[3] <= reg_data_wr;
        default: ;
      endcase
    end
  end

  dla_sheet_gen u_sheet_gen (
    .clock          (clock),
    .rst_n          (rst_n),
    .abort          (reg_init),
    .start          (gen_start),
    .init_begin     (init_begin),
    .kernel_size    (kernel_size),
    .stride         (stride),
    .pool_size      (pool_size),
    .if_tile_length (if_tile_length),
    .if_tile_height (if_tile_height),
    .if_tile_number (if_tile_number),
    .busy           (busy),
    .finish         (finish),
    .of_tile_length (of_tile_length),
    .of_tile_height (of_tile_height),
    .tile_count     (tile_count)
  );

  // Read mux on the registered address; REG_INIT and unmapped addresses read 0
  always_comb begin
    rd_word = '0;
    case (rd_addr_q)
      ADDR_KERNEL_SIZE:      rd_word = kernel_size;
      ADDR_STRIDE:           rd_word = stride;
      ADDR_PAD_SIZE:         rd_word = pad_size;
      ADDR_POOL_SIZE:        rd_word = pool_size;
      ADDR_VALID_NUM:        rd_word = valid_num;
      ADDR_IF_LAYER_NUM:     rd_word = if_layer_num;
      ADDR_IFMAP_LENGTH:     rd_word = ifmap_length;
      ADDR_IFMAP_SIZE:       rd_word = ifmap_size;
      ADDR_OFMAP_SIZE:       rd_word = ofmap_size;
      ADDR_QTF_MODE:         rd_word = qtf_mode;
      ADDR_POOL_MODE:        rd_word = pool_mode;
      ADDR_BIAS:             rd_word = bias;
      ADDR_BIAS_CHN:         rd_word = bias_chn;
      ADDR_OF_LAYER_NUM:     rd_word = of_layer_num;
      ADDR_IF_TILE_LENGTH_0: rd_word = if_tile_length[0];
      ADDR_IF_TILE_LENGTH_1: rd_word = if_tile_length[1];
      ADDR_IF_TILE_LENGTH_2: rd_word = if_tile_length[2];
      ADDR_IF_TILE_LENGTH_3: rd_word = if_tile_length[3];
      ADDR_IF_TILE_HEIGHT_0: rd_word = if_tile_height[0];
      ADDR_IF_TILE_HEIGHT_1: rd_word = if_tile_height[1];
      ADDR_IF_TILE_HEIGHT_2: rd_word = if_tile_height[2];
      ADDR_IF_TILE_HEIGHT_3: rd_word = if_tile_height[3];
      ADDR_IF_TILE_NUMBER_0: rd_word = if_tile_number[0];
      ADDR_IF_TILE_NUMBER_1: rd_word = if_tile_number[1];
      ADDR_IF_TILE_NUMBER_2: rd_word = if_tile_number[2];
      ADDR_IF_TILE_NUMBER_3: rd_word = if_tile_number[3];
      ADDR_SHEET_GEN_START:  rd_word = {31'd0, busy};
      ADDR_SHEET_GEN_FINISH: rd_word = {31'd0, finish};
      ADDR_OF_TILE_LENGTH_0: rd_word = of_tile_length[0];
      ADDR_OF_TILE_LENGTH_1: rd_word = of_tile_length[1];
      ADDR_OF_TILE_LENGTH_2: rd_word = of_tile_length[2];
      ADDR_OF_TILE_LENGTH_3: rd_word = of_tile_length[3];
      ADDR_OF_TILE_HEIGHT_0: rd_word = of_tile_height[0];
      ADDR_OF_TILE_HEIGHT_1: rd_word = of_tile_height[1];
      ADDR_OF_TILE_HEIGHT_2: rd_word = of_tile_height[2];
      ADDR_OF_TILE_HEIGHT_3: rd_word = of_tile_height[3];
      ADDR_TILE_COUNT:       rd_word = tile_count;
      default:               rd_word = '0;
    endcase
  end

  // Read port: the request is captured on one edge and the data register is
  // loaded on the next, so it shows the contents as they stood just before
  // that second edge's writes.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      reg_data_rd <= '0;
    end else begin
      rd_en_q     <= reg_en_rd;
      rd_addr_q   <= reg_addr_rd;
      reg_data_rd <= rd_en_q ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_dla_ctrl.sv
// tb_dla_ctrl
//   Self-checking bench for dla_ctrl: reset readback, a table of register
//   write/read vectors, hand-written generator sequences (test plan config,
//   disarmed start, write-while-busy, mid-walk abort, L<K) and randomized
//   generator runs compared against an arithmetic reference model.

`timescale 1ns/1ps

module tb_dla_ctrl;

  localparam logic [31:0] A_KERNEL   = 32'h01;
  localparam logic [31:0] A_STRIDE   = 32'h02;
  localparam logic [31:0] A_POOL     = 32'h04;
  localparam logic [31:0] A_IF_LEN0  = 32'h0f;
  localparam logic [31:0] A_IF_HGT0  = 32'h13;
  localparam logic [31:0] A_IF_NUM0  = 32'h17;
  localparam logic [31:0] A_INIT     = 32'h1b;
  localparam logic [31:0] A_START    = 32'h1c;
  localparam logic [31:0] A_FINISH   = 32'h1d;
  localparam logic [31:0] A_OF_LEN0  = 32'h1e;
  localparam logic [31:0] A_OF_HGT0  = 32'h22;
  localparam logic [31:0] A_COUNT    = 32'h26;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [31:0] reg_addr_wr;
  logic [31:0] reg_data_wr;
  logic        reg_en_wr;
  logic [31:0] reg_addr_rd;
  logic        reg_en_rd;
  logic [31:0] reg_data_rd;
  logic        init_begin;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_k, m_s, m_p;
  logic [31:0] m_len [4];
  logic [31:0] m_hgt [4];
  logic [31:0] m_num [4];

  typedef struct packed {
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  dla_ctrl dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .reg_addr_wr (reg_addr_wr),
    .reg_data_wr (reg_data_wr),
    .reg_en_wr   (reg_en_wr),
    .reg_addr_rd (reg_addr_rd),
    .reg_en_rd   (reg_en_rd),
    .reg_data_rd (reg_data_rd),
    .init_begin  (init_begin)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global timeout reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
    reg_addr_wr = addr;
    reg_data_wr = data;
    reg_en_wr   = 1'b1;
    tick();
    reg_en_wr   = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] addr, output logic [31:0] data);
    reg_addr_rd = addr;
    reg_en_rd   = 1'b1;
    tick();
    reg_en_rd   = 1'b0;
    tick();
    data = reg_data_rd;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] got;
    rd_reg(addr, got);
    checkOutput(name, got, expected);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [31:0] got;
    wr_reg(v.wr_addr, v.wr_data);
    rd_reg(v.rd_addr, got);
    checkOutput($sformatf("vec%0d rd 0x%0h", idx, v.rd_addr), got, v.exp);
  endtask

  // Reference: out = floor((floor((L-K)/stride') + 1) / pool') with 32-bit wrap,
  // where unsupported stride/pool sizes count as 1.
  function automatic logic [31:0] model_dim(input logic [31:0] d, input logic [31:0] k,
                                            input logic [31:0] s, input logic [31:0] p);
    logic [31:0] sd, pd, t;
    sd = (s == 32'd2 || s == 32'd4) ? s : 32'd1;
    pd = (p == 32'd2 || p == 32'd4) ? p : 32'd1;
    if (d < k) return 32'd0;
    t = (d - k) / sd;
    t = t + 32'd1;
    return t / pd;
  endfunction

  task automatic program_cfg();
    wr_reg(A_KERNEL, m_k);
    wr_reg(A_STRIDE, m_s);
    wr_reg(A_POOL, m_p);
    for (int i = 0; i < 4; i++) begin
      wr_reg(A_IF_LEN0 + 32'(i), m_len[i]);
      wr_reg(A_IF_HGT0 + 32'(i), m_hgt[i]);
      wr_reg(A_IF_NUM0 + 32'(i), m_num[i]);
    end
  endtask

  // Start the generator with finish being polled every cycle, measure when the
  // finish register turns 1, then compare every status register to the model.
  task automatic run_gen(input string tag);
    int unsigned sum;
    int cnt;
    sum = 0;
    for (int i = 0; i < 4; i++) sum += m_num[i];
    init_begin  = 1'b1;
    reg_addr_rd = A_FINISH;
    reg_en_rd   = 1'b1;
    wr_reg(A_START, 32'd1);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (reg_data_rd[0] !== 1'b1 && cnt < 300);
    reg_en_rd = 1'b0;
    tick();
    checkOutput({tag, " finish latency"}, 32'(cnt - 1), 32'(4 + sum + 1));
    for (int i = 0; i < 4; i++) begin
      rd_check($sformatf("%s of_len%0d", tag, i), A_OF_LEN0 + 32'(i), model_dim(m_len[i], m_k, m_s, m_p));
      rd_check($sformatf("%s of_hgt%0d", tag, i), A_OF_HGT0 + 32'(i), model_dim(m_hgt[i], m_k, m_s, m_p));
    end
    rd_check({tag, " tile_count"}, A_COUNT, 32'(sum));
    rd_check({tag, " busy"}, A_START, 32'd0);
    rd_check({tag, " finish"}, A_FINISH, 32'd1);
  endtask

  task automatic set_plan_cfg();
    m_k = 3; m_s = 1; m_p = 2;
    m_len = '{32'd32, 32'd24, 32'd32, 32'd24};
    m_hgt = '{32'd32, 32'd32, 32'd24, 32'd24};
    m_num = '{32'd3, 32'd3, 32'd3, 32'd1};
  endtask

  initial begin
    logic [31:0] opts [6];
    logic [31:0] plan_len [4];
    logic [31:0] plan_hgt [4];
    opts = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd8};
    plan_len = '{32'd15, 32'd11, 32'd15, 32'd11};
    plan_hgt = '{32'd15, 32'd15, 32'd11, 32'd11};

    vecs[0]  = '{32'h08,        32'd12996,     32'h08, 32'd12996};
    vecs[1]  = '{32'h01,        32'd3,         32'h01, 32'd3};
    vecs[2]  = '{32'h0c,        32'hDEADBEEF,  32'h0c, 32'hDEADBEEF};
    vecs[3]  = '{32'h1e,        32'd55,        32'h1e, 32'd0};
    vecs[4]  = '{32'h26,        32'd9,         32'h26, 32'd0};
    vecs[5]  = '{32'h30,        32'd7,         32'h30, 32'd0};
    vecs[6]  = '{32'h0100_0001, 32'd9,         32'h01, 32'd3};
    vecs[7]  = '{32'h1a,        32'd77,        32'h1a, 32'd77};
    vecs[8]  = '{32'h02,        32'd4,         32'h02, 32'd4};
    vecs[9]  = '{32'h1b,        32'd2,         32'h02, 32'd4};
    vecs[10] = '{32'h1b,        32'd2,         32'h1b, 32'd0};
    vecs[11] = '{32'h1c,        32'd1,         32'h1c, 32'd0};
    vecs[12] = '{32'h1b,        32'd1,         32'h08, 32'd0};
    vecs[13] = '{32'h1d,        32'd1,         32'h1d, 32'd0};

    rst_n = 1'b0;
    reg_addr_wr = '0; reg_data_wr = '0; reg_en_wr = 1'b0;
    reg_addr_rd = '0; reg_en_rd = 1'b0; init_begin = 1'b0;
    repeat (3) tick();
    checkOutput("reset reg_data_rd", reg_data_rd, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] reset readback");
    for (int a = 1; a <= 38; a++) rd_check($sformatf("reset rd 0x%0h", a), 32'(a), 32'd0);

    $display("[TB] register vectors");
    for (int i = 0; i < 14; i++) applyStimulus(i, vecs[i]);
    tick();
    checkOutput("rd data idle", reg_data_rd, 32'd0);

    $display("[TB] disarmed start");
    set_plan_cfg();
    program_cfg();
    init_begin = 1'b0;
    wr_reg(A_START, 32'd1);
    rd_check("disarmed busy", A_START, 32'd0);
    repeat (20) tick();
    rd_check("disarmed finish", A_FINISH, 32'd0);
    rd_check("disarmed tile_count", A_COUNT, 32'd0);

    $display("[TB] test plan run");
    run_gen("plan");
    for (int i = 0; i < 4; i++) begin
      rd_check($sformatf("plan const of_len%0d", i), A_OF_LEN0 + 32'(i), plan_len[i]);
      rd_check($sformatf("plan const of_hgt%0d", i), A_OF_HGT0 + 32'(i), plan_hgt[i]);
    end
    rd_check("plan const count", A_COUNT, 32'd10);
    wr_reg(A_INIT, 32'd1);
    rd_check("init clears finish", A_FINISH, 32'd0);

    $display("[TB] write while busy");
    program_cfg();
    init_begin = 1'b1;
    wr_reg(A_START, 32'd1);
    wr_reg(A_KERNEL, 32'd5);
    rd_check("busy high", A_START, 32'd1);
    repeat (30) tick();
    rd_check("kernel kept", A_KERNEL, 32'd3);
    rd_check("busy of_len0", A_OF_LEN0, 32'd15);
    rd_check("busy finish", A_FINISH, 32'd1);

    $display("[TB] abort mid-walk");
    wr_reg(A_INIT, 32'd1);
    program_cfg();
    wr_reg(A_START, 32'd1);
    repeat (5) tick();
    wr_reg(A_INIT, 32'd1);
    rd_check("abort finish", A_FINISH, 32'd0);
    rd_check("abort tile_count", A_COUNT, 32'd0);
    rd_check("abort busy", A_START, 32'd0);
    rd_check("abort kernel", A_KERNEL, 32'd0);
    repeat (30) tick();
    rd_check("abort finish later", A_FINISH, 32'd0);

    $display("[TB] tile shorter than kernel");
    m_k = 3; m_s = 2; m_p = 1;
    m_len = '{32'd2, 32'd3, 32'd4, 32'd100};
    m_hgt = '{32'd0, 32'd9, 32'd2, 32'd7};
    m_num = '{32'd1, 32'd0, 32'd2, 32'd0};
    program_cfg();
    run_gen("short");
    rd_check("short const of_len0", A_OF_LEN0, 32'd0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      m_k = $urandom_range(0, 8);
      m_s = opts[$urandom_range(0, 5)];
      m_p = opts[$urandom_range(0, 5)];
      for (int i = 0; i < 4; i++) begin
        m_len[i] = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                : 32'($urandom_range(0, 40));
        m_hgt[i] = 32'($urandom_range(0, 40));
        m_num[i] = 32'($urandom_range(0, 4));
      end
      program_cfg();
      run_gen($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
